xy_decim_pair: RTL

Averaging decimator and serializer that feeds the PI gain stage. It takes parallel signed X/Y samples, such as demodulated I/Q from the cavity-probe chain, and averages 2^LOG_N valid samples per channel. Each completed average is emitted as an interleaved pair on one 18-bit bus: X on the cycle `out_strobe` is high, Y on the following cycle. This is the exact pair protocol the downstream PI stage expects on its `in_d`/`in_strobe` inputs.

---
 rtl/xy_decim_pair.sv | 126 ++++++++++++
 1 files changed

// File: rtl/xy_decim_pair.sv
// Averaging decimator for paired X/Y samples: averages 2^LOG_N valid samples per channel
// and serializes each result as an X-then-Y pair on one bus for the downstream PI stage.
module xy_decim_pair #(
  parameter int LOG_N  = 4,
  parameter int DATA_W = 18
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] in_x,
  input  logic signed [DATA_W-1:0] in_y,
  input  logic                     in_valid,
  input  logic                     clear,
  output logic signed [DATA_W-1:0] out_d,
  output logic                     out_strobe,
  output logic                     out_pair,
  output logic                     overrun
);

  localparam int AW = DATA_W + LOG_N;
  localparam int CW = (LOG_N > 0) ? LOG_N : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((1 << LOG_N) - 1);

  typedef enum logic [1:0] {IDLE, EMIT_X, EMIT_Y} phase_t;

  logic signed [AW-1:0]     acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [AW-1:0]     sum_x, sum_y;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic signed [DATA_W-1:0] hold_x_q, hold_x_d, hold_y_q, hold_y_d;
  logic signed [DATA_W-1:0] out_d_q, out_d_d;
  logic                     strobe_q, strobe_d, pair_q, pair_d, ovr_q, ovr_d;
  phase_t                   ph_q, ph_d;

  // Arithmetic shift floors toward -infinity; the full-window sum always fits AW bits.
  function automatic logic signed [DATA_W-1:0] avg_trunc(input logic signed [AW-1:0] s);
    logic signed [AW-1:0] t;
    t = s >>> LOG_N;
    return t[DATA_W-1:0];
  endfunction

  assign sum_x = acc_x_q + AW'(in_x);
  assign sum_y = acc_y_q + AW'(in_y);

  always_comb begin
    acc_x_d  = acc_x_q;
    acc_y_d  = acc_y_q;
    cnt_d    = cnt_q;
    hold_x_d = hold_x_q;
    hold_y_d = hold_y_q;
    ovr_d    = ovr_q;
    case (ph_q)
      EMIT_X:  ph_d = EMIT_Y;
      default: ph_d = IDLE;
    endcase

    if (clear) begin
      acc_x_d = '0;
      acc_y_d = '0;
      cnt_d   = '0;
      ph_d    = IDLE;
      ovr_d   = 1'b0;
    end else if (in_valid) begin
      if (cnt_q == CNT_LAST) begin
        hold_x_d = avg_trunc(sum_x);
        hold_y_d = avg_trunc(sum_y);
        acc_x_d  = '0;
        acc_y_d  = '0;
        cnt_d    = '0;
        ph_d     = EMIT_X;
        if (ph_q == EMIT_X) ovr_d = 1'b1;
      end else begin
        acc_x_d = sum_x;
        acc_y_d = sum_y;
        cnt_d   = cnt_q + CW'(1);
      end
    end

    // Outputs are decoded from the next phase so they leave the block straight from flops.
    out_d_d  = '0;
    strobe_d = 1'b0;
    pair_d   = 1'b0;
    case (ph_d)
      EMIT_X: begin
        out_d_d  = hold_x_d;
        strobe_d = 1'b1;
        pair_d   = 1'b1;
      end
      EMIT_Y: begin
        out_d_d = hold_y_d;
        pair_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_x_q  <= '0;
      acc_y_q  <= '0;
      cnt_q    <= '0;
      hold_x_q <= '0;
      hold_y_q <= '0;
      ovr_q    <= 1'b0;
      ph_q     <= IDLE;
      out_d_q  <= '0;
      strobe_q <= 1'b0;
      pair_q   <= 1'b0;
    end else begin
      acc_x_q  <= acc_x_d;
      acc_y_q  <= acc_y_d;
      cnt_q    <= cnt_d;
      hold_x_q <= hold_x_d;
      hold_y_q <= hold_y_d;
      ovr_q    <= ovr_d;
      ph_q     <= ph_d;
      out_d_q  <= out_d_d;
      strobe_q <= strobe_d;
      pair_q   <= pair_d;
    end
  end

  assign out_d      = out_d_q;
  assign out_strobe = strobe_q;
  assign out_pair   = pair_q;
  assign overrun    = ovr_q;

endmodule
